// File: rtl/sprite_motion_ctrl_pkg.sv
// Shared StarSoC video parameters plus the types and helpers used by the
// sprite motion controller.
package starsoc_params;

  localparam int h_visible  = 640;
  localparam int v_visible  = 480;
  localparam int OBJ_HALF_W = 10;
  localparam int OBJ_HALF_H = 20;
  localparam int OBJ_STEP   = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SAMPLE = 3'd1,
    CALC_X = 3'd2,
    CALC_Y = 3'd3,
    COMMIT = 3'd4
  } motion_state_t;

  // Saturate a signed candidate position into [lo, hi]; never wraps.
  function automatic logic [9:0] clamp_pos(input logic signed [11:0] v,
                                           input logic signed [11:0] lo,
                                           input logic signed [11:0] hi);
    if (v < lo) begin
      return lo[9:0];
    end else if (v > hi) begin
      return hi[9:0];
    end else begin
      return v[9:0];
    end
  endfunction

  // Opposing requests cancel; a disabled frame contributes no motion.
  function automatic logic signed [11:0] step_delta(input logic inc,
                                                    input logic dec,
                                                    input logic en,
                                                    input logic signed [11:0] step);
    if (en && inc && !dec) begin
      return step;
    end else if (en && dec && !inc) begin
      return -step;
    end else begin
      return 12'sd0;
    end
  endfunction

endpackage

// File: rtl/sprite_motion_ctrl.sv
// Frame-synchronous object position controller: samples buttons once per
// vsync edge and commits a clamped position during blanking.
module sprite_motion_ctrl
  import starsoc_params::*;
#(
  parameter int H_VISIBLE = h_visible,
  parameter int V_VISIBLE = v_visible,
  parameter int HALF_W    = OBJ_HALF_W,
  parameter int HALF_H    = OBJ_HALF_H,
  parameter int STEP      = OBJ_STEP,
  parameter int FRAME_DIV = 1,
  parameter int INIT_X    = 320,
  parameter int INIT_Y    = 240
) (
  input  logic        pixel_clk,
  input  logic        reset_n,
  input  logic        vsync,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        pause,
  input  logic        center_req,
  output logic [9:0]  obj_x,
  output logic [9:0]  obj_y,
  output logic        update,
  output logic        busy,
  output logic [15:0] frame_cnt
);

  localparam logic signed [11:0] X_LO   = 12'(HALF_W);
  localparam logic signed [11:0] X_HI   = 12'(H_VISIBLE - HALF_W - 1);
  localparam logic signed [11:0] Y_LO   = 12'(HALF_H);
  localparam logic signed [11:0] Y_HI   = 12'(V_VISIBLE - HALF_H - 1);
  localparam logic signed [11:0] STEP_S = 12'(STEP);
  localparam logic [7:0]         DIV_LAST = 8'(FRAME_DIV - 1);
  localparam logic [9:0]         INIT_X_V = 10'(INIT_X);
  localparam logic [9:0]         INIT_Y_V = 10'(INIT_Y);

  motion_state_t r_state;
  motion_state_t w_state_nxt;

  logic        r_vsync_d;
  logic        w_accept;
  logic [7:0]  r_div_cnt;
  logic        r_move_en;
  logic        r_btn_u, r_btn_d, r_btn_l, r_btn_r, r_pause, r_lat_move;
  logic        w_en;
  logic [9:0]  r_nx, r_ny;
  logic        r_center_pend;
  logic [9:0]  r_obj_x, r_obj_y;
  logic        r_update, r_busy;
  logic [15:0] r_frame_cnt;

  assign w_accept = vsync && !r_vsync_d && (r_state == IDLE);
  assign w_en     = !r_pause && r_lat_move;

  // State register
  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: fixed walk through the sequence once an edge is accepted
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = SAMPLE;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      SAMPLE:  w_state_nxt = CALC_X;
      CALC_X:  w_state_nxt = CALC_Y;
      CALC_Y:  w_state_nxt = COMMIT;
      COMMIT:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Edge detect, divider, per-state datapath and registered outputs
  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vsync_d     <= 1'b0;
      r_div_cnt     <= 8'd0;
      r_move_en     <= 1'b0;
      r_btn_u       <= 1'b0;
      r_btn_d       <= 1'b0;
      r_btn_l       <= 1'b0;
      r_btn_r       <= 1'b0;
      r_pause       <= 1'b0;
      r_lat_move    <= 1'b0;
      r_nx          <= INIT_X_V;
      r_ny          <= INIT_Y_V;
      r_center_pend <= 1'b0;
      r_obj_x       <= INIT_X_V;
      r_obj_y       <= INIT_Y_V;
      r_update      <= 1'b0;
      r_busy        <= 1'b0;
      r_frame_cnt   <= 16'd0;
    end else begin
      r_vsync_d <= vsync;
      r_update  <= 1'b0;
      r_busy    <= (w_state_nxt != IDLE);

      if (w_accept) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
        if (r_div_cnt == DIV_LAST) begin
          r_div_cnt <= 8'd0;
          r_move_en <= 1'b1;
        end else begin
          r_div_cnt <= r_div_cnt + 8'd1;
          r_move_en <= 1'b0;
        end
      end

      case (r_state)
        SAMPLE: begin
          r_btn_u    <= btn_up;
          r_btn_d    <= btn_down;
          r_btn_l    <= btn_left;
          r_btn_r    <= btn_right;
          r_pause    <= pause;
          r_lat_move <= r_move_en;
        end
        CALC_X: r_nx <= clamp_pos(signed'({2'b00, r_obj_x}) +
                                  step_delta(r_btn_r, r_btn_l, w_en, STEP_S), X_LO, X_HI);
        CALC_Y: r_ny <= clamp_pos(signed'({2'b00, r_obj_y}) +
                                  step_delta(r_btn_d, r_btn_u, w_en, STEP_S), Y_LO, Y_HI);
        COMMIT: begin
          // A request landing in this very cycle still counts for this commit
          if (r_center_pend || center_req) begin
            r_obj_x <= INIT_X_V;
            r_obj_y <= INIT_Y_V;
          end else begin
            r_obj_x <= r_nx;
            r_obj_y <= r_ny;
          end
          r_update <= 1'b1;
        end
        default: begin
        end
      endcase

      if (r_state == COMMIT) begin
        r_center_pend <= 1'b0;
      end else if (center_req) begin
        r_center_pend <= 1'b1;
      end
    end
  end

  assign obj_x     = r_obj_x;
  assign obj_y     = r_obj_y;
  assign update    = r_update;
  assign busy      = r_busy;
  assign frame_cnt = r_frame_cnt;

endmodule

// File: doc/sprite_motion_ctrl.md
# sprite_motion_ctrl

Frame-synchronous position controller for the on-screen object drawn by the video generator. Samples direction buttons once per frame at the vsync rising edge, computes a clamped new position, and commits it atomically during vertical blanking so the object never tears mid-frame. Sits between the board button inputs and the video generator's object-position inputs, in the `pixel_clk` domain.

## Interface
- `H_VISIBLE`, 640, visible width in pixels.
- `V_VISIBLE`, 480, visible height in lines.
- `HALF_W`, 10, object half-width in pixels.
- `HALF_H`, 20, object half-height in lines.
- `STEP`, 4, pixels moved per movement frame, range 1..15.
- `FRAME_DIV`, 1, move once every `FRAME_DIV` frames, range 1..255.
- `INIT_X`, 320, reset and recenter x. Must lie within the x clamp range.
- `INIT_Y`, 240, reset and recenter y. Must lie within the y clamp range.

Ports:
- `pixel_clk`  in  1  pixel clock, 25 MHz.
- `reset_n`  in  1  asynchronous, active-low reset.
- `vsync`  in  1  frame sync from the timing generator. Active-high level.
- `btn_up`, `btn_down`, `btn_left`, `btn_right`  in  1 each  direction requests. Already synchronous and debounced.
- `pause`  in  1  suppresses motion while high.
- `center_req`  in  1  one-cycle pulse requesting a recenter at the next commit.
- `obj_x`  out  10  object centre x, in visible-area coordinates.
- `obj_y`  out  10  object centre y, in visible-area coordinates.
- `update`  out  1  one-cycle pulse on each commit.
- `busy`  out  1  high whenever the state is not IDLE.
- `frame_cnt`  out  16  count of detected frames; wraps at 2^16.

## Operation
- Reset values: `obj_x`=`INIT_X`, `obj_y`=`INIT_Y`, `update`=0, `busy`=0, `frame_cnt`=0. Divider counter and `center_pend` are 0. State is IDLE.
- Frame detect: `vsync_d` is a registered copy of `vsync`. A frame edge is `vsync & ~vsync_d`.
  - Edges are acted on only in IDLE. An edge seen in any other state is ignored and not queued.
- `center_req` sets the sticky flag `center_pend` in any state. `center_pend` is cleared in COMMIT.
- Divider: on each accepted edge, `frame_cnt` increments.
  - If `div_cnt == FRAME_DIV-1`, `move_en`=1 and `div_cnt` resets to 0.
  - Otherwise `div_cnt` increments and `move_en`=0.
- FSM states: IDLE → SAMPLE → CALC_X → CALC_Y → COMMIT → IDLE.
  - IDLE: wait for an accepted edge.
  - SAMPLE: latch the four buttons, `pause` and `move_en`.
  - CALC_X: compute `nx`.
    - dx = +`STEP` if right only; −`STEP` if left only; 0 if both or neither.
    - dx = 0 if pause or !move_en.
  - CALC_Y: compute `ny` the same way. Down is +, up is −. Up+down together cancels.
  - COMMIT: write `obj_x`/`obj_y` and pulse `update`.
    - If `center_pend`, write `INIT_X`/`INIT_Y` instead of `nx`/`ny`. Recenter wins over motion, pause and the divider.
- Arithmetic: sums use 12-bit signed values, then clamp.
  - x is clamped to [`HALF_W`, `H_VISIBLE-HALF_W-1`].
  - y is clamped to [`HALF_H`, `V_VISIBLE-HALF_H-1`].
  - There is no wrap-around. A step past a bound lands exactly on the bound.
- Reset asserted mid-sequence returns everything to reset values immediately. No partial commit occurs.

## Timing
- Edge detected at clock edge E0 (IDLE→SAMPLE). Then SAMPLE at E1, CALC_X at E2, CALC_Y at E3.
- Commit: `obj_x`/`obj_y` change at E4 (COMMIT→IDLE). `update` is high for exactly the cycle following E4.
- Latency is 4 cycles, far shorter than vertical blanking. Outputs are stable for the whole visible frame.
- Buttons are sampled only in SAMPLE. Changes at any other time have no effect until the next frame.
- `center_req` arriving in COMMIT's cycle is applied in that same commit.
- `busy` is high from E0 through E4.

## Structure
- `starsoc_params` gains:
  - the `motion_state_t` enum (IDLE, SAMPLE, CALC_X, CALC_Y, COMMIT);
  - the constants `OBJ_HALF_W`, `OBJ_HALF_H`, `OBJ_STEP`;
  - the parameter defaults, which reuse the existing `h_visible`/`v_visible`.
- Single module. No sub-module is needed: the edge detect, divider and clamp are inline.

## Test plan
- Reset, then hold `btn_right`, 5 frames, `FRAME_DIV`=1 → `obj_x`=340, `obj_y`=240, 5 `update` pulses.
- `obj_x`=628, hold right, 2 frames → `obj_x`=629 then stays 629.
- `btn_left`+`btn_right` together, 3 frames → `obj_x` unchanged. `update` still pulses each frame.
- `FRAME_DIV`=3, hold `btn_down`, 6 frames → `obj_y` moves 240→244→248, only on frames 3 and 6. `frame_cnt`=6.
- `pause`=1 with `btn_up` held, and `center_req` pulsed at position (100,50) → next commit gives (320,240).
- `reset_n` pulled low during CALC_Y → outputs at (320,240) immediately; no `update` pulse. The next vsync edge is processed normally.
